// File: rtl/multi_channel_timer.sv
// Multi-channel system timer: NUM_CH independent prescaled down-counters behind
// a simple sel/addr/wen bus, each with periodic/one-shot mode and a W1C expiry flag.
`timescale 1ns/1ps
module multi_channel_timer #(
  parameter int NUM_CH  = 4,
  parameter int CNT_W   = 32,
  parameter int PRESC_W = 8,
  parameter int ADDR_W  = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sel,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  input  logic              wen,
  output logic [31:0]       rdata,
  output logic              irq
);

  localparam int CH_W = ADDR_W - 2;
  localparam logic [ADDR_W-1:0] IRQ_STAT_ADDR = ADDR_W'(4 * NUM_CH);
  localparam logic [ADDR_W-1:0] FLAGS_ADDR    = ADDR_W'(4 * NUM_CH + 1);

  logic [NUM_CH-1:0]  en, ie, oneshot, flag;
  logic [PRESC_W-1:0] presc [NUM_CH];
  logic [PRESC_W-1:0] pcnt  [NUM_CH];
  logic [CNT_W-1:0]   load  [NUM_CH];
  logic [CNT_W-1:0]   val   [NUM_CH];

  logic              wr, rd, in_ch;
  logic [CH_W-1:0]   ch_sel;
  logic [1:0]        off;
  logic [NUM_CH-1:0] ch_hit, ctrl_wr, load_wr, val_wr, flag_clr, tick, expire;
  logic [31:0]       rd_data;
  logic              unused_wdata;

  assign wr     = sel & wen;
  assign rd     = sel & ~wen;
  assign ch_sel = addr[ADDR_W-1:2];
  assign off    = addr[1:0];
  assign in_ch  = addr < IRQ_STAT_ADDR;
  assign unused_wdata = ^wdata;

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    ch_hit   = '0;
    ctrl_wr  = '0;
    load_wr  = '0;
    val_wr   = '0;
    flag_clr = '0;
    tick     = '0;
    expire   = '0;
    for (int n = 0; n < NUM_CH; n++) begin
      ch_hit[n]   = in_ch && (ch_sel == CH_W'(n));
      ctrl_wr[n]  = wr && ch_hit[n] && (off == 2'd0);
      load_wr[n]  = wr && ch_hit[n] && (off == 2'd1);
      val_wr[n]   = wr && ch_hit[n] && (off == 2'd2);
      flag_clr[n] = (ctrl_wr[n] && wdata[16]) || (wr && (addr == IRQ_STAT_ADDR) && wdata[n]);
      tick[n]     = en[n] && (pcnt[n] == presc[n]);
      expire[n]   = tick[n] && (val[n] == '0);
    end
  end

  // NOTE: all state, including the per-channel register arrays, is cleared by
  // reset and updated with non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en      <= '0;
      ie      <= '0;
      oneshot <= '0;
      flag    <= '0;
      for (int n = 0; n < NUM_CH; n++) begin
        presc[n] <= '0;
        pcnt[n]  <= '0;
        load[n]  <= '0;
        val[n]   <= '0;
      end
    end else begin
      for (int n = 0; n < NUM_CH; n++) begin
        if (val_wr[n] || !en[n] || tick[n]) pcnt[n] <= '0;
        else                                pcnt[n] <= pcnt[n] + PRESC_W'(1);

        // A software VAL write takes precedence over the tick's decrement/reload.
        if (val_wr[n])                        val[n] <= wdata[CNT_W-1:0];
        else if (tick[n] && val[n] != '0)     val[n] <= val[n] - CNT_W'(1);
        else if (expire[n] && !oneshot[n])    val[n] <= load[n];

        // Hardware expiry beats a simultaneous W1C from either path.
        if (expire[n])        flag[n] <= 1'b1;
        else if (flag_clr[n]) flag[n] <= 1'b0;

        if (ctrl_wr[n]) begin
          en[n]      <= wdata[0];
          ie[n]      <= wdata[1];
          oneshot[n] <= wdata[2];
          presc[n]   <= wdata[8 +: PRESC_W];
        end else if (expire[n] && oneshot[n]) begin
          en[n] <= 1'b0;
        end

        if (load_wr[n]) load[n] <= wdata[CNT_W-1:0];
      end
    end
  end

  always_comb begin
    rd_data = '0;
    if (in_ch) begin
      for (int n = 0; n < NUM_CH; n++) begin
        if (ch_hit[n]) begin
          case (off)
            2'd0:    rd_data = {15'b0, flag[n], 8'(presc[n]), 5'b0, oneshot[n], ie[n], en[n]};
            2'd1:    rd_data = 32'(load[n]);
            2'd2:    rd_data = 32'(val[n]);
            default: rd_data = '0;
          endcase
        end
      end
    end else if (addr == IRQ_STAT_ADDR) begin
      rd_data = 32'(flag & ie);
    end else if (addr == FLAGS_ADDR) begin
      rd_data = 32'(flag);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  rdata <= '0;
    else if (rd) rdata <= rd_data;
  end

  assign irq = |(flag & ie);

endmodule

// File: tb/tb_multi_channel_timer.sv
// Directed self-checking bench for multi_channel_timer (NUM_CH=4, CNT_W=16).
`timescale 1ns/1ps
module tb_multi_channel_timer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sel = 1'b0;
  logic [4:0]  addr = '0;
  logic [31:0] wdata = '0;
  logic        wen = 1'b0;
  logic [31:0] rdata;
  logic        irq;

  int checks = 0;
  int failures = 0;

  multi_channel_timer #(.NUM_CH(4), .CNT_W(16), .PRESC_W(8), .ADDR_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .sel(sel), .addr(addr),
    .wdata(wdata), .wen(wen), .rdata(rdata), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // All tasks start and end 1 ns after a rising edge.
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [4:0] a, input logic [31:0] d);
    sel = 1'b1; wen = 1'b1; addr = a; wdata = d;
    @(posedge clk); #1;
    sel = 1'b0; wen = 1'b0; wdata = '0;
  endtask

  task automatic read_check(input string tag, input logic [4:0] a, input logic [31:0] exp);
    sel = 1'b1; wen = 1'b0; addr = a;
    @(posedge clk); #1;
    sel = 1'b0;
    check(tag, rdata, exp);
  endtask

  initial begin
    // Power-on reset
    #12;
    check("por_irq", {31'b0, irq}, 32'd0);
    check("por_rdata", rdata, 32'd0);
    rst_n = 1'b1;
    idle(1);

    // Periodic ch0: LOAD=3, VAL=3, EN|IE, PRESC=0 -> flag every 4 cycles
    bus_write(5'd1, 32'd3);
    bus_write(5'd2, 32'd3);
    bus_write(5'd0, 32'h3);             // edge E0
    idle(3);
    check("per_before_e4", {31'b0, irq}, 32'd0);
    idle(1);
    check("per_e4", {31'b0, irq}, 32'd1);
    bus_write(5'd16, 32'h1);            // E5 clear
    check("per_clr_e5", {31'b0, irq}, 32'd0);
    idle(2);
    check("per_before_e8", {31'b0, irq}, 32'd0);
    idle(1);
    check("per_e8", {31'b0, irq}, 32'd1);

    // W1C collisions with hardware set
    bus_write(5'd16, 32'h1);            // E9
    check("clr_e9", {31'b0, irq}, 32'd0);
    idle(2);
    bus_write(5'd16, 32'h1);            // E12 = expiry edge
    check("coll_stat_w1c", {31'b0, irq}, 32'd1);
    bus_write(5'd16, 32'h1);            // E13
    check("clr_e13", {31'b0, irq}, 32'd0);
    idle(2);
    bus_write(5'd0, 32'h0001_0003);     // E16 = expiry edge, CTRL W1C path
    check("coll_ctrl_w1c", {31'b0, irq}, 32'd1);
    bus_write(5'd2, 32'd7);             // E17 tick edge, VAL write wins
    read_check("coll_val_write", 5'd2, 32'd7);
    bus_write(5'd0, 32'h0001_0000);     // E19 disable, clear flag (VAL 6->5 here)
    check("ch0_off_irq", {31'b0, irq}, 32'd0);
    read_check("ch0_off_ctrl", 5'd0, 32'd0);
    read_check("ch0_val_held", 5'd2, 32'd5);

    // One-shot ch1 with PRESC=2
    bus_write(5'd5, 32'd2);
    bus_write(5'd6, 32'd2);
    bus_write(5'd4, 32'h0000_0207);     // F0
    idle(3);
    read_check("os_val_f4", 5'd6, 32'd1);
    idle(2);
    check("os_irq_f6", {31'b0, irq}, 32'd0);
    read_check("os_val_f7", 5'd6, 32'd0);
    idle(1);
    check("os_irq_f8", {31'b0, irq}, 32'd0);
    idle(1);
    check("os_irq_f9", {31'b0, irq}, 32'd1);
    read_check("os_ctrl", 5'd4, 32'h0001_0206);
    idle(6);
    read_check("os_val_stays", 5'd6, 32'd0);
    check("os_irq_level", {31'b0, irq}, 32'd1);
    bus_write(5'd4, 32'h0001_0000);
    check("os_clr", {31'b0, irq}, 32'd0);

    // Multi-channel: LOAD/VAL = n+1, only ch2 interrupt-enabled
    for (int n = 0; n < 4; n++) begin
      bus_write(5'(4 * n + 1), 32'(n + 1));
      bus_write(5'(4 * n + 2), 32'(n + 1));
      bus_write(5'(4 * n), (n == 2) ? 32'h3 : 32'h1);
    end
    idle(20);
    read_check("mc_flags_all", 5'd17, 32'hF);
    read_check("mc_irq_stat", 5'd16, 32'h4);
    check("mc_irq_on", {31'b0, irq}, 32'd1);
    bus_write(5'd0,  32'h0001_0001);
    bus_write(5'd4,  32'h0001_0001);
    bus_write(5'd12, 32'h0001_0001);
    check("mc_irq_ch2_only", {31'b0, irq}, 32'd1);
    bus_write(5'd8, 32'h0001_0000);
    check("mc_irq_ch2_off", {31'b0, irq}, 32'd0);
    idle(10);
    check("mc_irq_stays_off", {31'b0, irq}, 32'd0);
    read_check("mc_flags_no_ch2", 5'd17, 32'hB);
    read_check("mc_stat_zero", 5'd16, 32'h0);
    for (int n = 0; n < 4; n++) bus_write(5'(4 * n), 32'h0001_0000);

    // Map holes, truncation and read latency
    read_check("hole_global", 5'd18, 32'd0);
    read_check("hole_ch1_p3", 5'd7, 32'd0);
    bus_write(5'd13, 32'hFFFF_FFFF);
    bus_write(5'd18, 32'h5);
    read_check("hole_write_ignored", 5'd18, 32'd0);
    sel = 1'b1; wen = 1'b0; addr = 5'd13;
    #2;
    check("lat_before_edge", rdata, 32'd0);
    @(posedge clk); #1;
    check("lat_one_cycle", rdata, 32'h0000_FFFF);
    sel = 1'b0; addr = 5'd18;
    idle(2);
    check("rdata_holds", rdata, 32'h0000_FFFF);

    // Reset mid-count
    bus_write(5'd1, 32'd9);
    bus_write(5'd2, 32'd5);
    bus_write(5'd0, 32'h3);             // G0
    idle(2);
    read_check("pre_rst_val", 5'd2, 32'd3);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_rdata", rdata, 32'd0);
    check("rst_irq", {31'b0, irq}, 32'd0);
    #3;
    rst_n = 1'b1;
    idle(1);
    read_check("rst_ctrl", 5'd0, 32'd0);
    read_check("rst_load", 5'd1, 32'd0);
    read_check("rst_val", 5'd2, 32'd0);
    read_check("rst_load3", 5'd13, 32'd0);
    idle(8);
    read_check("rst_no_flag", 5'd17, 32'd0);
    check("rst_irq_after", {31'b0, irq}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multi_channel_timer.md
Name: multi_channel_timer

Overview:
Parametrised successor to the single-channel system timer. Provides NUM_CH independent down-counters. Each channel has its own prescaler, periodic or one-shot mode, write-1-to-clear expiry flag and interrupt enable. Sits on the peripheral bus behind the same sel/addr/wen/wdata/rdata interface and drives one aggregated level interrupt to the core.

Parameters:
NUM_CH, 4, number of timer channels (1..8)
CNT_W, 32, counter/LOAD/VAL width in bits (1..32)
PRESC_W, 8, prescaler field width (1..8)
ADDR_W, 5, word-address width; must satisfy 2^ADDR_W > 4*NUM_CH

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
sel  input  1  block select from bus decoder
addr  input  ADDR_W  word address
wdata  input  32  write data
wen  input  1  write enable, qualified by sel
rdata  output  32  registered read data
irq  output  1  aggregated level interrupt

Behaviour:
- Reset: one clock, clk. Reset is asynchronous and active-low on rst_n. Asserting it clears every register, prescaler and rdata to 0. irq is 0. Reset mid-count abandons the count with no flag set.
- Register map, channel n at base 4n:
  - +0 CTRL: [0] EN, [1] IE, [2] ONESHOT, [15:8] PRESC (upper bits beyond PRESC_W read 0), [16] FLAG (RO, W1C).
  - +1 LOAD.
  - +2 VAL.
  - +3 reads 0.
- Global registers:
  - 4*NUM_CH IRQ_STAT: bit n = FLAG_n & IE_n. Writing 1 to bit n clears FLAG_n.
  - 4*NUM_CH+1 FLAGS: raw FLAG vector, RO.
  - All other addresses read 0; writes to them are ignored.
- Width: writes truncate to CNT_W; reads zero-extend.
- Write (sel & wen): takes effect at the clock edge.
  - CTRL write updates EN, IE, ONESHOT and PRESC. wdata[16]=1 clears FLAG.
  - VAL write loads VAL <= wdata directly and clears the channel prescaler. FLAG is untouched.
- Read (sel & !wen): rdata <= addressed register at the edge, so data is valid 1 cycle after the address (1-cycle latency). Otherwise rdata holds. Reads have no side effects.
- Prescaler: per-channel count pcnt.
  - When EN=0, pcnt is held at 0.
  - When EN=1, pcnt increments each cycle. tick fires when pcnt==PRESC, and pcnt then returns to 0. The result is one tick every PRESC+1 cycles; PRESC=0 gives a tick every cycle.
- On tick:
  - VAL!=0: VAL <= VAL-1.
  - VAL==0 and periodic: VAL <= LOAD and FLAG <= 1. Period = (LOAD+1)*(PRESC+1) cycles.
  - VAL==0 and ONESHOT: FLAG <= 1, EN <= 0, VAL stays 0.
- LOAD=0 in periodic mode: FLAG is set on every tick.
- Simultaneous events, same channel, same edge:
  - Hardware FLAG set beats a W1C clear (either path); FLAG ends at 1.
  - A software VAL write beats the tick decrement/reload; the prescaler is cleared.
  - A software CTRL write of EN beats the one-shot auto-clear.
- irq = OR over n of (FLAG_n & IE_n). It is combinational from registers, with no other gating. It is a level signal that stays high until the flag is cleared or IE is dropped.
- Channels are fully independent; no cross-channel reload or chaining.

Test Plan:
- Reset: drive rst_n low mid-count with ch0 EN=1 and VAL=5 -> all CTRL/LOAD/VAL read 0, irq=0, rdata=0 immediately after reset.
- Periodic: ch0 LOAD=3, VAL=3, CTRL=0x3 (PRESC=0) -> FLAG set on the 4th cycle after enable, then every 4 cycles. irq rises with FLAG. Writing IRQ_STAT=0x1 drops irq one cycle later.
- Prescaler plus one-shot: ch1 LOAD=2, VAL=2, CTRL=0x0207 (PRESC=2, ONESHOT) -> VAL decrements every 3 cycles. FLAG sets 9 cycles after enable. EN reads 0 and VAL stays 0 thereafter.
- Collision: W1C of ch0 FLAG on the same edge hardware sets it -> FLAG reads 1 and irq stays high. VAL write of 7 on a tick edge -> VAL reads 7, not decremented.
- Multi-channel: all NUM_CH=4 channels with distinct LOAD 1/2/3/4, only ch2 IE=1 -> FLAGS shows all bits set over time. IRQ_STAT=0x4 only, and irq follows ch2 alone.
- Read latency and map holes: read addr 4*NUM_CH+2 -> 0. Read ch3 LOAD after writing 0xFFFF_FFFF with CNT_W=16 -> 0x0000_FFFF, valid exactly one cycle after the address is presented.
